// File: rtl/pwm_multi.sv
// -----------------------------------------------------------------------------
// pwm_multi
//   Multi-channel PWM generator. All channels share one period counter. The
//   period, the alignment mode and the per-channel duty values are
//   double-buffered: cfg_wr captures them into pending registers, and they are
//   copied into the active set only at a period boundary (count == 0 while
//   enabled). This means a running waveform never shows a truncated or extra
//   pulse. While disabled, the pending set is copied through immediately.
//
// Ports
//   clk          in   1          system clock, rising edge
//   rst_n        in   1          asynchronous reset, active low
//   en           in   1          1 = run, 0 = counter held at 0 and outputs low
//   period       in   WIDTH      counter top value, captured by cfg_wr
//   mode         in   1          0 = edge-aligned, 1 = center-aligned
//   duty         in   NCH*WIDTH  channel i duty = duty[i*WIDTH +: WIDTH]
//   cfg_wr       in   1          single-cycle strobe that captures period/mode/duty
//   PWM_sig      out  NCH        registered PWM outputs
//   period_start out  1          registered pulse on the first output cycle of a period
// -----------------------------------------------------------------------------
module pwm_multi #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [WIDTH-1:0]     period,
  input  logic                 mode,
  input  logic [NCH*WIDTH-1:0] duty,
  input  logic                 cfg_wr,
  output logic [NCH-1:0]       PWM_sig,
  output logic                 period_start
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Pending (shadow) configuration
  logic [WIDTH-1:0]     per_pend_q, per_pend_d;
  logic                 mode_pend_q, mode_pend_d;
  logic [NCH*WIDTH-1:0] duty_pend_q, duty_pend_d;
  logic                 pend_vld_q, pend_vld_d;

  // Active configuration
  logic [WIDTH-1:0]     per_act_q, per_act_d;
  logic                 mode_act_q, mode_act_d;
  logic [NCH*WIDTH-1:0] duty_act_q, duty_act_d;

  // Counter and outputs
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic                 dir_q, dir_d;
  logic [NCH-1:0]       pwm_q, pwm_d;
  logic                 pstart_q, pstart_d;

  logic                 boundary;
  logic                 byp;
  logic                 ld_pend;

  // ---------------------------------------------------------------------------
  // Configuration update. The "effective" values (written into the active set)
  // are also what the counter and comparators use in the boundary cycle, so the
  // output produced from count 0 already belongs to the new period.
  // ---------------------------------------------------------------------------
  always_comb begin
    boundary = en && (cnt_q == '0);
    byp      = boundary && cfg_wr;
    ld_pend  = pend_vld_q && (boundary || !en) && !byp;

    per_act_d  = per_act_q;
    mode_act_d = mode_act_q;
    duty_act_d = duty_act_q;
    if (byp) begin
      per_act_d  = period;
      mode_act_d = mode;
      duty_act_d = duty;
    end else if (ld_pend) begin
      per_act_d  = per_pend_q;
      mode_act_d = mode_pend_q;
      duty_act_d = duty_pend_q;
    end

    per_pend_d  = per_pend_q;
    mode_pend_d = mode_pend_q;
    duty_pend_d = duty_pend_q;
    pend_vld_d  = pend_vld_q;
    if (cfg_wr && !byp) begin
      per_pend_d  = period;
      mode_pend_d = mode;
      duty_pend_d = duty;
      pend_vld_d  = 1'b1;
    end else if (ld_pend || byp) begin
      // A bypass write supersedes anything still pending.
      pend_vld_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared period counter
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = '0;
    dir_d = DIR_UP;
    if (en && (per_act_d != '0)) begin
      if (!mode_act_d) begin
        cnt_d = (cnt_q >= per_act_d) ? '0 : cnt_q + ONE;
      end else if (cnt_q == '0) begin
        cnt_d = ONE;
        dir_d = DIR_UP;
      end else if ((cnt_q >= per_act_d) || (dir_q == DIR_DOWN)) begin
        // Turning at the top (>= guards against any stale count above P).
        cnt_d = cnt_q - ONE;
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + ONE;
        dir_d = DIR_UP;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output comparators (registered, one cycle behind the count)
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pwm_d[i] = en && (cnt_q < duty_act_d[i*WIDTH +: WIDTH]);
    end
    pstart_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_pend_q  <= '0;
      mode_pend_q <= 1'b0;
      duty_pend_q <= '0;
      pend_vld_q  <= 1'b0;
      per_act_q   <= '0;
      mode_act_q  <= 1'b0;
      duty_act_q  <= '0;
      cnt_q       <= '0;
      dir_q       <= DIR_UP;
      pwm_q       <= '0;
      pstart_q    <= 1'b0;
    end else begin
      per_pend_q  <= per_pend_d;
      mode_pend_q <= mode_pend_d;
      duty_pend_q <= duty_pend_d;
      pend_vld_q  <= pend_vld_d;
      per_act_q   <= per_act_d;
      mode_act_q  <= mode_act_d;
      duty_act_q  <= duty_act_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      pwm_q       <= pwm_d;
      pstart_q    <= pstart_d;
    end
  end

  assign PWM_sig      = pwm_q;
  assign period_start = pstart_q;

endmodule
